// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I data-memory path: bridge FSM states and
// the default transaction timeout.
package rv32i_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

  localparam int unsigned DMEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rv32i_bus_timer.sv
// 8-bit transaction watchdog: counts while enabled, flags the cycle in which
// the count sits at TIMEOUT_CYCLES-1.
module rv32i_bus_timer
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rv32i_dmem_bridge.sv
// Bridges the LSU's combinational load/store request onto the registered
// request/grant/response data bus, stalling the core until the response.
module rv32i_dmem_bridge
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        st_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] wmem_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rmem_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdat_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdat_i,
  input  logic        bus_err_i
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_ADDR = 2'(ADDR);
  localparam logic [1:0] S_RESP = 2'(RESP);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       err_q;
  logic       accept;
  logic       expired;
  logic       abort;

  assign accept = (state == S_IDLE) && req_i;
  // A response arriving in the expiry cycle still counts as completion.
  assign abort  = expired && ((state == S_ADDR) || ((state == S_RESP) && !bus_rvalid_i));

  rv32i_bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (accept),
    .enable  ((state == S_ADDR) || (state == S_RESP)),
    .expired (expired)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (req_i) state_nx = S_ADDR;
      S_ADDR: begin
        if (expired) state_nx = S_DONE;
        else if (bus_gnt_i) state_nx = S_RESP;
      end
      S_RESP: if (bus_rvalid_i || expired) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      bus_we_o   <= 1'b0;
      bus_addr_o <= '0;
      bus_wdat_o <= '0;
      bus_be_o   <= '0;
      rmem_o     <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        bus_we_o   <= st_i;
        bus_addr_o <= mem_addr_i & 32'hFFFF_FFFC;
        bus_wdat_o <= wmem_i;
        bus_be_o   <= be_i;
        err_q      <= 1'b0;
      end
      if ((state == S_RESP) && bus_rvalid_i) begin
        if (!bus_we_o) rmem_o <= bus_rdat_i;
        err_q <= bus_err_i;
      end else if (abort) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus_req_o = (state == S_ADDR);
  assign stall_o   = req_i && (state != S_DONE);
  assign err_o     = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_rv32i_dmem_bridge.sv
// Scoreboard bench for rv32i_dmem_bridge: directed test-plan accesses plus
// randomized loads/stores with waits, timeouts, bus errors, flushes and noise.
module tb_rv32i_dmem_bridge;

  localparam int T = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        st_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] wmem_i = '0;
  logic [3:0]  be_i = '0;
  logic [31:0] rmem_o;
  logic        stall_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdat_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdat_i = '0;
  logic        bus_err_i = 1'b0;

  rv32i_dmem_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .st_i         (st_i),
    .mem_addr_i   (mem_addr_i),
    .wmem_i       (wmem_i),
    .be_i         (be_i),
    .rmem_o       (rmem_o),
    .stall_o      (stall_o),
    .err_o        (err_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdat_o   (bus_wdat_o),
    .bus_be_o     (bus_be_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdat_i   (bus_rdat_i),
    .bus_err_i    (bus_err_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          addr_lo;
    int          addr_hi;
    int          done_at;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  be;
    logic [31:0] rmem;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  logic [31:0] rmem_model = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every cycle compares outputs against the transaction at the head
  // of the scoreboard; the head is retired in its predicted DONE cycle.
  exp_t mon_e;
  bit   mon_has, mon_done, mon_addr;
  always @(negedge clk_i) begin
    if (mon_en) begin
      mon_has  = (exp_q.size() > 0);
      if (mon_has) mon_e = exp_q[0];
      mon_done = mon_has && (cyc == mon_e.done_at);
      mon_addr = mon_has && (cyc >= mon_e.addr_lo) && (cyc <= mon_e.addr_hi);
      checkOutput("stall", stall_o, req_i && !mon_done);
      checkOutput("bus_req", bus_req_o, mon_addr);
      checkOutput("err", err_o, mon_done ? mon_e.err : 1'b0);
      if (mon_addr) begin
        checkOutput("bus_we", bus_we_o, mon_e.we);
        checkOutput("bus_addr", bus_addr_o, mon_e.addr);
        checkOutput("bus_wdat", bus_wdat_o, mon_e.wdat);
        checkOutput("bus_be", bus_be_o, mon_e.be);
      end
      if (mon_done) begin
        checkOutput("rmem", rmem_o, mon_e.rmem);
        void'(exp_q.pop_front());
      end
    end
  end

  // Drives one access as the LSU plus bus slave. Reference outcome: the slave
  // grants after g waits and answers r cycles later; ADDR+RESP may last at most
  // T cycles, a grant in the T-th cycle is too late, a response in it is not.
  task automatic applyStimulus(input logic st, input logic [31:0] addr, input logic [31:0] wdat,
                               input logic [3:0] be, input int g, input int r,
                               input logic [31:0] rdat, input logic berr,
                               input bit flush, input int gap);
    int   addr_cyc, len, rv_cyc, flush_at;
    bit   timed, in_addr, in_resp;
    exp_t e;
    timed    = (g + 1 >= T) || (g + 2 + r > T);
    addr_cyc = (g + 1 >= T) ? T : g + 1;
    len      = timed ? T : g + 2 + r;
    rv_cyc   = g + 2 + r;
    flush_at = flush ? int'($urandom_range(len, 1)) : 0;
    if (!timed && !st) rmem_model = rdat;
    e.addr_lo = cyc + 1;
    e.addr_hi = cyc + addr_cyc;
    e.done_at = cyc + len + 1;
    e.we      = st;
    e.addr    = {addr[31:2], 2'b00};
    e.wdat    = wdat;
    e.be      = be;
    e.rmem    = rmem_model;
    e.err     = timed ? 1'b1 : berr;
    req_i = 1'b1; st_i = st; mem_addr_i = addr; wmem_i = wdat; be_i = be;
    exp_q.push_back(e);
    for (int c = 0; c <= len + 1; c++) begin
      if (c > 0) begin
        @(posedge clk_i); #1;
        mem_addr_i = $urandom; wmem_i = $urandom; be_i = 4'($urandom);
      end
      in_addr = (c >= 1) && (c <= addr_cyc);
      in_resp = (c > addr_cyc) && (c <= len);
      if (flush_at != 0 && c >= flush_at) req_i = 1'b0;
      bus_gnt_i = in_addr ? (c == g + 1) : ($urandom_range(2, 0) == 0);
      if (in_resp) begin
        bus_rvalid_i = (c == rv_cyc);
        bus_rdat_i   = (c == rv_cyc) ? rdat : $urandom;
        bus_err_i    = (c == rv_cyc) ? berr : 1'($urandom);
      end else begin
        bus_rvalid_i = ($urandom_range(2, 0) == 0);
        bus_rdat_i   = $urandom;
        bus_err_i    = 1'($urandom);
      end
    end
    @(posedge clk_i); #1;
    for (int i = 0; i < gap; i++) begin
      req_i = 1'b0; mem_addr_i = $urandom; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    #1;
    checkOutput("reset_rmem", rmem_o, 32'h0);
    checkOutput("reset_err", err_o, 1'b0);
    checkOutput("reset_bus_req", bus_req_o, 1'b0);
    checkOutput("reset_bus_addr", bus_addr_o, 32'h0);
    checkOutput("reset_bus_be", bus_be_o, 4'h0);
    @(posedge clk_i); #1;
    rst_i  = 1'b0;
    mon_en = 1'b1;
    @(posedge clk_i); #1;

    applyStimulus(1'b0, 32'h0000_0104, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 32'h0000_0203, 32'hAB00_0000, 4'h8, 2, 3, 32'h1234_5678, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 32'h0000_0300, 32'h0, 4'hF, 100, 0, 32'h5555_5555, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 32'h0000_0400, 32'h0, 4'hF, 1, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 32'h0000_0500, 32'h0, 4'hF, 0, 0, 32'h1111_1111, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 32'h0000_0504, 32'h0, 4'hF, 0, 0, 32'h2222_2222, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 32'h0000_0600, 32'h0, 4'hF, 1, 2, 32'h3333_3333, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 32'h0000_0700, 32'h0, 4'hF, 3, 3, 32'h4444_4444, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 32'h0000_0704, 32'h0, 4'hF, 2, 4, 32'h6666_6666, 1'b0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom), $urandom, $urandom, 4'($urandom_range(15, 1)),
                    int'($urandom_range(9, 0)), int'($urandom_range(6, 0)), $urandom,
                    ($urandom_range(7, 0) == 0), ($urandom_range(5, 0) == 0),
                    int'($urandom_range(2, 0)));
    end

    @(posedge clk_i); #1;
    mon_en = 1'b0;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    req_i = 1'b1; st_i = 1'b0; mem_addr_i = 32'h0000_0800; be_i = 4'hF;
    @(posedge clk_i); #1;
    bus_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus_gnt_i = 1'b0;
    #3 rst_i = 1'b1;
    #1;
    checkOutput("midreset_bus_req", bus_req_o, 1'b0);
    checkOutput("midreset_bus_we", bus_we_o, 1'b0);
    checkOutput("midreset_bus_addr", bus_addr_o, 32'h0);
    checkOutput("midreset_bus_wdat", bus_wdat_o, 32'h0);
    checkOutput("midreset_bus_be", bus_be_o, 4'h0);
    checkOutput("midreset_rmem", rmem_o, 32'h0);
    checkOutput("midreset_err", err_o, 1'b0);
    checkOutput("midreset_stall", stall_o, 1'b1);
    @(posedge clk_i); #1;
    rst_i = 1'b0; req_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdat_i = 32'hFFFF_FFFF; bus_err_i = 1'b1;
    @(posedge clk_i); #1;
    bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    @(posedge clk_i); #1;
    checkOutput("late_rvalid_rmem", rmem_o, 32'h0);
    checkOutput("late_rvalid_err", err_o, 1'b0);
    checkOutput("late_rvalid_bus_req", bus_req_o, 1'b0);
    checkOutput("late_rvalid_stall", stall_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
